// File: rtl/dbg_uart_pkg.sv
// Shared definitions for the debug-terminal UART transmit path.
// ASCII constants, hex-digit mapping, baud divisor and FSM states.
package dbg_uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  // Uppercase hex digit for one nibble
  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Whole clock cycles per serial bit
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready load port.
// Ready also in the last stop-bit cycle so frames run back to back.
module uart_tx_byte
  import dbg_uart_pkg::*;
#(
  parameter int CPB = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_txd
);

  localparam int BW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);

  logic          r_busy;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [8:0]    r_shift;
  logic          r_txd;

  logic w_bit_end;
  logic w_frame_end;
  logic w_load;

  assign w_bit_end   = (r_baud == BAUD_LAST);
  assign w_frame_end = r_busy && w_bit_end && (r_bit == 4'd9);
  assign o_ready     = !r_busy || w_frame_end;
  assign w_load      = i_valid && o_ready;
  assign o_txd       = r_txd;

  // Baud/bit counting, shifting and the line flop; bit 9 is the stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= 4'd0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else if (w_load) begin
      r_busy  <= 1'b1;
      r_baud  <= '0;
      r_bit   <= 4'd0;
      r_shift <= {1'b1, i_data};
      r_txd   <= 1'b0;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_bit  <= 4'd0;
          r_txd  <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_txd   <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_baud <= r_baud + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Prints a 32-bit word as 8 uppercase hex chars (+ optional CR LF).
// Next character is loaded in the serializer's last stop-bit cycle.
module uart_hex_tx
  import dbg_uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD        = 115_200,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        txd,
  output logic [7:0]  tx_char
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int NCHAR = APPEND_CRLF ? 10 : 8;
  localparam logic [3:0] LAST_IDX = 4'(NCHAR - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_word;
  logic [3:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_char;

  logic [31:0] w_sel_word;
  logic [3:0]  w_sel_idx;
  logic [3:0]  w_nib;
  logic [7:0]  w_char;
  logic        w_load;
  logic        w_fin;
  logic        w_ready;

  uart_tx_byte #(
    .CPB(CPB)
  ) u_byte (
    .clk    (clk),
    .rst    (rst),
    .i_valid(w_load),
    .i_data (w_char),
    .o_ready(w_ready),
    .o_txd  (txd)
  );

  // LOAD is a zero-time phase: accept and first char load share one edge
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_fin      = 1'b0;
    w_sel_word = r_word;
    w_sel_idx  = r_idx + 4'd1;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next     = SEND;
          w_load     = 1'b1;
          w_sel_word = data_in;
          w_sel_idx  = 4'd0;
        end
      end
      SEND: begin
        if (w_ready) begin
          if (r_idx == LAST_IDX) begin
            w_next = IDLE;
            w_fin  = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      LOAD:    w_next = SEND;
      default: w_next = IDLE;
    endcase
  end

  // Character select: nibble 0 is bits [31:28], then CR and LF
  always_comb begin
    w_nib = w_sel_word[{~w_sel_idx[2:0], 2'b11} -: 4];
    if (w_sel_idx == 4'd8)      w_char = ASCII_CR;
    else if (w_sel_idx == 4'd9) w_char = ASCII_LF;
    else                        w_char = hex2ascii(w_nib);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Word, index, and registered busy/done/tx_char
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= 4'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_char <= 8'h00;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_busy <= 1'b1;
        r_idx  <= w_sel_idx;
        r_char <= w_char;
        if (r_state == IDLE) r_word <= data_in;
      end else if (w_fin) begin
        r_busy <= 1'b0;
        r_idx  <= 4'd0;
        r_char <= 8'h00;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign tx_char = r_char;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: CRLF and no-CRLF instances, mid-bit receivers.
// Expected strings are queued at start; receivers pop and compare.
module tb_uart_hex_tx;

  localparam int CF  = 16;
  localparam int BD  = 1;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] din0 = '0, din1 = '0;
  logic        busy0, done0, txd0;
  logic        busy1, done1, txd1;
  logic [7:0]  ch0, ch1;

  int n_vec = 0;
  int n_err = 0;
  int rst_epoch = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  uart_hex_tx #(
    .CLK_FREQ(CF), .BAUD(BD), .APPEND_CRLF(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .start(start0), .data_in(din0),
    .busy(busy0), .done(done0), .txd(txd0), .tx_char(ch0)
  );

  uart_hex_tx #(
    .CLK_FREQ(CF), .BAUD(BD), .APPEND_CRLF(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst), .start(start1), .data_in(din1),
    .busy(busy1), .done(done1), .txd(txd1), .tx_char(ch1)
  );

  always #5 clk = ~clk;

  always @(posedge rst) rst_epoch++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic g_txd(input int k);
    return k ? txd1 : txd0;
  endfunction
  function automatic logic g_busy(input int k);
    return k ? busy1 : busy0;
  endfunction
  function automatic logic g_done(input int k);
    return k ? done1 : done0;
  endfunction
  function automatic logic [7:0] g_char(input int k);
    return k ? ch1 : ch0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_start(input int k, input logic v, input logic [31:0] d);
    if (k != 0) begin start1 = v; din1 = d; end
    else        begin start0 = v; din0 = d; end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle
  task automatic xmit(input int k, input logic [31:0] d, input string s,
                      input bit poke);
    int total;
    int nd;
    total = 10 * s.len() * CPB;
    nd = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (k != 0) q1.push_back(s[i]);
      else        q0.push_back(s[i]);
    end
    set_start(k, 1'b1, d);
    @(posedge clk);
    #1 set_start(k, 1'b0, d);
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (g_done(k)) nd++;
      if (c == 1) begin
        chk("busy_first", g_busy(k), 1);
        chk("txd_start", g_txd(k), 0);
      end
      if (c == total) chk("busy_last", g_busy(k), 1);
      if (c == total + 1) begin
        chk("done_cycle", g_done(k), 1);
        chk("busy_done", g_busy(k), 0);
        chk("txd_idle", g_txd(k), 1);
        chk("char_idle", g_char(k), 0);
      end
      if (poke && c == 50) set_start(k, 1'b1, 32'hDEADBEEF);
      if (poke && c == 51) set_start(k, 1'b0, 32'hDEADBEEF);
    end
    chk("done_pulses", nd, 1);
  endtask

  // Mid-bit receiver; frames cut by reset are discarded
  task automatic rx_mon(input int k);
    logic [7:0] b;
    logic [7:0] cs;
    logic [7:0] e;
    logic       sb, stp;
    int         ep;
    forever begin
      @(negedge clk);
      if (!rst && g_txd(k) == 1'b0) begin
        ep = rst_epoch;
        repeat (8) @(negedge clk);
        sb = g_txd(k);
        cs = g_char(k);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = g_txd(k);
        end
        repeat (16) @(negedge clk);
        stp = g_txd(k);
        if (ep == rst_epoch && !rst) begin
          if ((k != 0 ? q1.size() : q0.size()) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_extra: got char %h expected none", b);
          end else begin
            e = (k != 0) ? q1.pop_front() : q0.pop_front();
            chk("rx_char", b, e);
            chk("tx_char", cs, e);
            chk("rx_startbit", sb, 0);
            chk("rx_stopbit", stp, 1);
          end
        end
      end
    end
  endtask

  initial rx_mon(0);
  initial rx_mon(1);

  initial begin
    int nd;
    #1 rst = 1'b1;
    #2;
    chk("rst_txd", txd1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_char", ch1, 0);
    chk("rst_txd_n", txd0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic string, with an ignored start re-pulse at cycle 50
    xmit(1, 32'h1234ABCD, "1234ABCD\r\n", 1'b1);
    repeat (5) @(negedge clk);
    xmit(1, 32'h00000000, "00000000\r\n", 1'b0);
    repeat (5) @(negedge clk);
    xmit(1, 32'hFFFFFFFF, "FFFFFFFF\r\n", 1'b0);
    repeat (5) @(negedge clk);

    // back-to-back: start held in the done cycle
    xmit(1, 32'h00C0FFEE, "00C0FFEE\r\n", 1'b0);
    xmit(1, 32'h0F0F0F0F, "0F0F0F0F\r\n", 1'b0);
    repeat (5) @(negedge clk);

    // no CR LF instance
    xmit(0, 32'hCAFE0001, "CAFE0001", 1'b0);
    repeat (5) @(negedge clk);

    // reset in the middle of the 3rd character
    set_start(1, 1'b1, 32'h89ABCDEF);
    q1.push_back(8'h38);
    q1.push_back(8'h39);
    @(posedge clk);
    #1 set_start(1, 1'b0, 32'h89ABCDEF);
    repeat (400) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txd", txd1, 1);
    chk("midrst_busy", busy1, 0);
    chk("midrst_char", ch1, 0);
    chk("midrst_q", q1.size(), 0);
    nd = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done1) nd++;
    end
    chk("midrst_nodone", nd, 0);
    xmit(1, 32'h13579BDF, "13579BDF\r\n", 1'b0);

    repeat (20) @(negedge clk);
    chk("q_drain_c", q1.size(), 0);
    chk("q_drain_n", q0.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
